// File: rtl/opb_snapshot_bank_simulink2ppc.sv
// OPB slave that captures C_NUM_CH user words atomically into a shadow bank (one-shot or continuous).
// Define SNAP_TIMESTAMP_EN to latch a free-running cycle counter with every capture.
module opb_snapshot_bank_simulink2ppc #(
  parameter logic [31:0] C_BASEADDR = 32'h01180700,
  parameter logic [31:0] C_HIGHADDR = 32'h011807FF,
  parameter int          C_NUM_CH   = 4,
  parameter int          C_USER_DW  = 32
) (
  input  logic                          OPB_Clk,
  input  logic                          OPB_Rst_n,
  input  logic [0:31]                   OPB_ABus,
  input  logic [0:3]                    OPB_BE,
  input  logic [0:31]                   OPB_DBus,
  input  logic                          OPB_RNW,
  input  logic                          OPB_select,
  input  logic                          OPB_seqAddr,
  output logic [0:31]                   Sl_DBus,
  output logic                          Sl_xferAck,
  output logic                          Sl_errAck,
  output logic                          Sl_retry,
  output logic                          Sl_toutSup,
  input  logic [C_NUM_CH*C_USER_DW-1:0] user_data_in,
  input  logic                          user_valid,
  output logic                          snap_done
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ARMED = 2'd1,
    ST_DONE  = 2'd2
  } state_e;

  // Numeric views of the big-endian buses: register bit n is bus bit 31-n.
  logic [31:0] addr, offset, wdata;
  assign addr   = OPB_ABus;
  assign wdata  = OPB_DBus;
  assign offset = addr - C_BASEADDR;

  logic        ack_q, rnw_q, be3_q;
  logic [29:0] widx_q;
  logic [2:0]  wbits_q;
  logic        hit;

  // A pending ack blocks a new hit, so a held select is answered every other cycle.
  assign hit = OPB_select && (addr >= C_BASEADDR) && (addr <= C_HIGHADDR) && !ack_q;

  // NOTE: sequential state uses non-blocking assignments only, so every flop samples pre-edge values.
  always_ff @(posedge OPB_Clk or negedge OPB_Rst_n) begin
    if (!OPB_Rst_n) begin
      ack_q   <= 1'b0;
      rnw_q   <= 1'b0;
      be3_q   <= 1'b0;
      widx_q  <= '0;
      wbits_q <= '0;
    end else begin
      ack_q <= hit;
      if (hit) begin
        rnw_q   <= OPB_RNW;
        be3_q   <= OPB_BE[3];
        widx_q  <= offset[31:2];
        wbits_q <= wdata[2:0];
      end
    end
  end

  // Writes commit on the edge that ends the ack cycle.
  logic ctrl_wr, arm_wr, clr_wr;
  assign ctrl_wr = ack_q && !rnw_q && be3_q && (widx_q == 30'd0);
  assign arm_wr  = ctrl_wr && wbits_q[0];
  assign clr_wr  = ctrl_wr && wbits_q[2];

  state_e      state_q, state_d;
  logic [7:0]  missed_q, missed_d;
  logic        mode_q;
  logic        capture;

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    state_d  = state_q;
    missed_d = missed_q;
    capture  = 1'b0;
    unique case (state_q)
      ST_IDLE:  if (arm_wr) state_d = ST_ARMED;
      ST_ARMED: begin
        if (user_valid) begin
          capture = 1'b1;
          if (!mode_q) state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        if (arm_wr) begin
          state_d  = ST_ARMED;
          missed_d = '0;
        end else if (user_valid && missed_q != 8'hFF) begin
          missed_d = missed_q + 8'd1;
        end
      end
      default:  state_d = ST_IDLE;
    endcase
    // Clear overrides everything, including an arm in the same write.
    if (clr_wr) begin
      state_d  = ST_IDLE;
      missed_d = '0;
      capture  = 1'b0;
    end
  end

  always_ff @(posedge OPB_Clk or negedge OPB_Rst_n) begin
    if (!OPB_Rst_n) begin
      state_q  <= ST_IDLE;
      missed_q <= '0;
      mode_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      missed_q <= missed_d;
      if (ctrl_wr) mode_q <= wbits_q[1];
    end
  end

  logic [C_USER_DW-1:0] chan_q [C_NUM_CH];

  // NOTE: the shadow bank is plain flops, reset explicitly so every channel reads 0 after reset.
  always_ff @(posedge OPB_Clk or negedge OPB_Rst_n) begin
    if (!OPB_Rst_n) begin
      for (int i = 0; i < C_NUM_CH; i++) chan_q[i] <= '0;
    end else if (clr_wr) begin
      for (int i = 0; i < C_NUM_CH; i++) chan_q[i] <= '0;
    end else if (capture) begin
      for (int i = 0; i < C_NUM_CH; i++) chan_q[i] <= user_data_in[i*C_USER_DW +: C_USER_DW];
    end
  end

`ifdef SNAP_TIMESTAMP_EN
  logic [31:0] ts_cnt_q, ts_q;

  always_ff @(posedge OPB_Clk or negedge OPB_Rst_n) begin
    if (!OPB_Rst_n) begin
      ts_cnt_q <= '0;
      ts_q     <= '0;
    end else begin
      ts_cnt_q <= ts_cnt_q + 32'd1;
      if (clr_wr)       ts_q <= '0;
      else if (capture) ts_q <= ts_cnt_q;
    end
  end
`endif

  // Read data is driven only during a read ack, so a same-cycle capture is not yet visible.
  logic [31:0] rdata;
  always_comb begin
    rdata = '0;
    if (ack_q && rnw_q) begin
      if (widx_q == 30'd0) rdata = {29'b0, 1'b0, mode_q, 1'b0};
      if (widx_q == 30'd1) rdata = {16'b0, missed_q, 6'b0, state_q == ST_DONE, state_q == ST_ARMED};
      for (int i = 0; i < C_NUM_CH; i++) begin
        if (widx_q == 30'(i + 2)) rdata = 32'(chan_q[i]);
      end
`ifdef SNAP_TIMESTAMP_EN
      if (widx_q == 30'(C_NUM_CH + 2)) rdata = ts_q;
`endif
    end
  end

  assign Sl_DBus    = rdata;
  assign Sl_xferAck = ack_q;
  assign Sl_errAck  = 1'b0;
  assign Sl_retry   = 1'b0;
  assign Sl_toutSup = 1'b0;
  assign snap_done  = (state_q == ST_DONE);

  logic unused_ok;
  assign unused_ok = ^{OPB_seqAddr, OPB_BE[0:2], wdata[31:3], offset[1:0]};

endmodule

// File: tb/tb_opb_snapshot_bank_simulink2ppc.sv
// Self-checking bench: table of bus/strobe vectors plus hand-written corner sequences,
// with read results checked by a scoreboard queue when the DUT acks.
module tb_opb_snapshot_bank_simulink2ppc;

  localparam logic [31:0] BASE   = 32'h01180700;
  localparam int          NUM_CH = 4;
  localparam int          DW     = 32;
  localparam logic [7:0]  TS_OFF = 8'(8 + 4 * NUM_CH);

  logic                 clk = 1'b0;
  logic                 rst_n = 1'b0;
  logic [0:31]          OPB_ABus = '0;
  logic [0:3]           OPB_BE = '0;
  logic [0:31]          OPB_DBus = '0;
  logic                 OPB_RNW = 1'b1;
  logic                 OPB_select = 1'b0;
  logic                 OPB_seqAddr = 1'b0;
  logic [0:31]          Sl_DBus;
  logic                 Sl_xferAck, Sl_errAck, Sl_retry, Sl_toutSup;
  logic [NUM_CH*DW-1:0] user_data_in = '0;
  logic                 user_valid = 1'b0;
  logic                 snap_done;

  always #5 clk = ~clk;

  opb_snapshot_bank_simulink2ppc dut (
    .OPB_Clk     (clk),
    .OPB_Rst_n   (rst_n),
    .OPB_ABus    (OPB_ABus),
    .OPB_BE      (OPB_BE),
    .OPB_DBus    (OPB_DBus),
    .OPB_RNW     (OPB_RNW),
    .OPB_select  (OPB_select),
    .OPB_seqAddr (OPB_seqAddr),
    .Sl_DBus     (Sl_DBus),
    .Sl_xferAck  (Sl_xferAck),
    .Sl_errAck   (Sl_errAck),
    .Sl_retry    (Sl_retry),
    .Sl_toutSup  (Sl_toutSup),
    .user_data_in(user_data_in),
    .user_valid  (user_valid),
    .snap_done   (snap_done)
  );

  int n_checks = 0;
  int n_errors = 0;
  int ack_count = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  // Reference cycle count: posedges since reset release, same as the optional DUT counter.
  logic [31:0] tb_cycle;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) tb_cycle <= '0;
    else        tb_cycle <= tb_cycle + 32'd1;
  end

  typedef struct {
    string       name;
    logic        check_data;
    logic [31:0] exp;
  } sb_t;
  sb_t sb_q[$];

  // Scoreboard: every ack consumes one expectation; idle cycles must show a zero data bus.
  always @(negedge clk) begin : monitor
    sb_t e;
    if (Sl_xferAck === 1'b1) begin
      ack_count++;
      if (sb_q.size() == 0) begin
        check("unexpected_ack", 32'd1, 32'd0);
      end else begin
        e = sb_q.pop_front();
        if (e.check_data) check(e.name, Sl_DBus, e.exp);
      end
    end else begin
      check("dbus_zero_when_idle", Sl_DBus, 32'd0);
    end
  end

  task automatic set_user(input logic [31:0] d);
    for (int i = 0; i < NUM_CH; i++) user_data_in[i*DW +: DW] = d * 32'(i + 1);
  endtask

  task automatic pulses(input logic [31:0] d, input int n);
    for (int k = 0; k < n; k++) begin
      set_user(d + 32'(k));
      user_valid = 1'b1;
      @(negedge clk);
    end
    user_valid = 1'b0;
  endtask

  // One OPB transfer starting at a negedge; optionally raises user_valid during the ack cycle.
  task automatic bus_xfer(input logic rnw, input logic [7:0] off, input logic [3:0] be,
                          input logic [31:0] wd, input logic [31:0] exp, input string name,
                          input logic pulse_at_ack, input logic [31:0] pulse_data);
    sb_t e;
    int  waits;
    bit  got;
    e.name = name;
    e.check_data = rnw;
    e.exp = exp;
    sb_q.push_back(e);
    OPB_ABus = BASE + 32'(off);
    OPB_RNW = rnw;
    OPB_BE = be;
    OPB_DBus = wd;
    OPB_select = 1'b1;
    got = 1'b0;
    waits = 0;
    while (!got && waits < 4) begin
      @(negedge clk);
      waits++;
      if (Sl_xferAck === 1'b1) got = 1'b1;
    end
    check({name, "_ack_latency"}, 32'(waits), 32'd1);
    if (!got) void'(sb_q.pop_back());
    if (got && pulse_at_ack) begin
      set_user(pulse_data);
      user_valid = 1'b1;
    end
    OPB_select = 1'b0;
    OPB_RNW = 1'b1;
    OPB_BE = '0;
    OPB_DBus = '0;
    OPB_ABus = '0;
    @(negedge clk);
    user_valid = 1'b0;
  endtask

  task automatic rd(input logic [7:0] off, input logic [31:0] exp, input string name);
    bus_xfer(1'b1, off, 4'hF, 32'd0, exp, name, 1'b0, 32'd0);
  endtask

  task automatic wr(input logic [7:0] off, input logic [3:0] be, input logic [31:0] d, input string name);
    bus_xfer(1'b0, off, be, d, 32'd0, name, 1'b0, 32'd0);
  endtask

  typedef enum {OP_WR, OP_RD, OP_PULSE, OP_SNAP} op_e;
  typedef struct {
    op_e         op;
    logic [7:0]  off;
    logic [3:0]  be;
    logic [31:0] data;
    int          n;
    logic [31:0] exp;
    string       name;
  } vec_t;
  vec_t vecs[$];

  function automatic void add(input op_e op, input logic [7:0] off, input logic [3:0] be,
                              input logic [31:0] data, input int n, input logic [31:0] exp,
                              input string name);
    vec_t v;
    v.op = op; v.off = off; v.be = be; v.data = data; v.n = n; v.exp = exp; v.name = name;
    vecs.push_back(v);
  endfunction

  logic [31:0] ts_k, ts_exp;
  int          acks_before;

  initial begin : watchdog
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    // ---- vector table (offsets: CTRL 0x00, STATUS 0x04, CHi 0x08+4i) ----
    add(OP_RD,    8'h04, 4'h0, 0,          0, 32'h0,    "status_after_reset");
    add(OP_RD,    8'h00, 4'h0, 0,          0, 32'h0,    "ctrl_after_reset");
    add(OP_RD,    8'h08, 4'h0, 0,          0, 32'h0,    "ch0_after_reset");
    add(OP_WR,    8'h00, 4'h1, 32'h1,      0, 0,        "arm_oneshot");
    add(OP_RD,    8'h04, 4'h0, 0,          0, 32'h1,    "status_armed");
    add(OP_SNAP,  8'h00, 4'h0, 0,          0, 32'h0,    "snap_done_armed");
    add(OP_PULSE, 8'h00, 4'h0, 32'h11,     1, 0,        "capture_11");
    add(OP_RD,    8'h08, 4'h0, 0,          0, 32'h11,   "ch0_oneshot");
    add(OP_RD,    8'h0C, 4'h0, 0,          0, 32'h22,   "ch1_oneshot");
    add(OP_RD,    8'h10, 4'h0, 0,          0, 32'h33,   "ch2_oneshot");
    add(OP_RD,    8'h14, 4'h0, 0,          0, 32'h44,   "ch3_oneshot");
    add(OP_RD,    8'h04, 4'h0, 0,          0, 32'h2,    "status_done");
    add(OP_SNAP,  8'h00, 4'h0, 0,          0, 32'h1,    "snap_done_done");
    add(OP_PULSE, 8'h00, 4'h0, 32'h99,   300, 0,        "missed_300");
    add(OP_RD,    8'h04, 4'h0, 0,          0, 32'hFF02, "status_missed_saturated");
    add(OP_RD,    8'h08, 4'h0, 0,          0, 32'h11,   "ch0_held_in_done");
    add(OP_WR,    8'h00, 4'h1, 32'h1,      0, 0,        "rearm");
    add(OP_RD,    8'h04, 4'h0, 0,          0, 32'h1,    "status_rearmed");
    add(OP_SNAP,  8'h00, 4'h0, 0,          0, 32'h0,    "snap_done_rearmed");
    add(OP_WR,    8'h00, 4'h1, 32'h3,      0, 0,        "arm_continuous");
    add(OP_RD,    8'h00, 4'h0, 0,          0, 32'h2,    "ctrl_mode1");
    add(OP_PULSE, 8'h00, 4'h0, 32'h5,      3, 0,        "capture_5_6_7");
    add(OP_RD,    8'h08, 4'h0, 0,          0, 32'h7,    "ch0_continuous");
    add(OP_RD,    8'h14, 4'h0, 0,          0, 32'h1C,   "ch3_continuous");
    add(OP_RD,    8'h04, 4'h0, 0,          0, 32'h1,    "status_continuous");
    add(OP_WR,    8'h00, 4'h0, 32'h4,      0, 0,        "clear_with_be0");
    add(OP_RD,    8'h04, 4'h0, 0,          0, 32'h1,    "status_after_be0");
    add(OP_RD,    8'h08, 4'h0, 0,          0, 32'h7,    "ch0_after_be0");
    add(OP_WR,    8'h30, 4'hF, 32'hFFFFFFFF, 0, 0,      "wr_unmapped");
    add(OP_RD,    8'h30, 4'h0, 0,          0, 32'h0,    "rd_unmapped");
    add(OP_RD,    8'hFC, 4'h0, 0,          0, 32'h0,    "rd_window_top");
    add(OP_RD,    8'h00, 4'h0, 0,          0, 32'h2,    "ctrl_after_unmapped_wr");
    add(OP_WR,    8'h00, 4'h1, 32'h5,      0, 0,        "clear_and_arm");
    add(OP_RD,    8'h04, 4'h0, 0,          0, 32'h0,    "status_after_clear");
    add(OP_RD,    8'h00, 4'h0, 0,          0, 32'h0,    "ctrl_after_clear");
    add(OP_RD,    8'h08, 4'h0, 0,          0, 32'h0,    "ch0_after_clear");
    add(OP_RD,    8'h0C, 4'h0, 0,          0, 32'h0,    "ch1_after_clear");
    add(OP_RD,    8'h10, 4'h0, 0,          0, 32'h0,    "ch2_after_clear");
    add(OP_RD,    8'h14, 4'h0, 0,          0, 32'h0,    "ch3_after_clear");
    add(OP_PULSE, 8'h00, 4'h0, 32'h77,     1, 0,        "valid_in_idle");
    add(OP_RD,    8'h08, 4'h0, 0,          0, 32'h0,    "ch0_no_capture_idle");

    // ---- reset ----
    repeat (3) @(negedge clk);
    check("reset_xferack", 32'(Sl_xferAck), 32'd0);
    check("reset_dbus", Sl_DBus, 32'd0);
    check("reset_snap_done", 32'(snap_done), 32'd0);
    check("tied_off_outputs", 32'({Sl_errAck, Sl_retry, Sl_toutSup}), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    foreach (vecs[i]) begin
      case (vecs[i].op)
        OP_WR:    wr(vecs[i].off, vecs[i].be, vecs[i].data, vecs[i].name);
        OP_RD:    rd(vecs[i].off, vecs[i].exp, vecs[i].name);
        OP_PULSE: pulses(vecs[i].data, vecs[i].n);
        default:  check(vecs[i].name, 32'(snap_done), vecs[i].exp);
      endcase
    end

    // ---- held select: one ack every other cycle ----
    acks_before = ack_count;
    for (int k = 0; k < 3; k++) sb_q.push_back('{name: "held_select_status", check_data: 1'b1, exp: 32'h0});
    OPB_ABus = BASE + 32'h4;
    OPB_RNW = 1'b1;
    OPB_select = 1'b1;
    repeat (6) @(negedge clk);
    OPB_select = 1'b0;
    @(negedge clk);
    check("held_select_ack_count", 32'(ack_count - acks_before), 32'd3);

    // ---- addresses just outside the window get no ack ----
    acks_before = ack_count;
    OPB_ABus = BASE + 32'h100;
    OPB_select = 1'b1;
    repeat (3) @(negedge clk);
    OPB_ABus = BASE - 32'h4;
    repeat (3) @(negedge clk);
    OPB_select = 1'b0;
    OPB_ABus = '0;
    @(negedge clk);
    check("out_of_window_no_ack", 32'(ack_count - acks_before), 32'd0);

    // ---- arm write and user_valid on the same edge: no capture ----
    bus_xfer(1'b0, 8'h00, 4'h1, 32'h1, 32'h0, "arm_with_valid", 1'b1, 32'h55);
    rd(8'h04, 32'h1, "status_arm_with_valid");
    rd(8'h08, 32'h0, "ch0_no_capture_on_arm");
    pulses(32'h66, 1);
    rd(8'h08, 32'h66, "ch0_after_arm_then_valid");

    // ---- channel read and capture in the same cycle: pre-capture value ----
    wr(8'h00, 4'h1, 32'h1, "arm_for_read_race");
    bus_xfer(1'b1, 8'h08, 4'hF, 32'h0, 32'h66, "ch0_pre_capture", 1'b1, 32'h88);
    rd(8'h08, 32'h88, "ch0_post_capture");
    rd(8'h04, 32'h2, "status_after_read_race");

    // ---- mode change while armed applies from the next cycle ----
    wr(8'h00, 4'h1, 32'h3, "arm_mode1_again");
    bus_xfer(1'b0, 8'h00, 4'h1, 32'h0, 32'h0, "mode0_with_valid", 1'b1, 32'h21);
    rd(8'h04, 32'h1, "status_old_mode_used");
    rd(8'h08, 32'h21, "ch0_old_mode_capture");
    pulses(32'h31, 1);
    rd(8'h04, 32'h2, "status_new_mode_used");
    rd(8'h08, 32'h31, "ch0_new_mode_capture");

    // ---- capture timestamp ----
    wr(8'h00, 4'h1, 32'h1, "arm_for_timestamp");
    ts_k = tb_cycle;
`ifdef SNAP_TIMESTAMP_EN
    ts_exp = ts_k;
`else
    ts_exp = 32'h0;
`endif
    pulses(32'h41, 1);
    rd(TS_OFF, ts_exp, "timestamp_at_capture");
    wr(8'h00, 4'h1, 32'h4, "clear_timestamp");
    rd(TS_OFF, 32'h0, "timestamp_after_clear");
    rd(8'h08, 32'h0, "ch0_after_clear2");

    // ---- asynchronous reset in the middle of an ack while armed ----
    wr(8'h00, 4'h1, 32'h3, "arm_before_reset");
    pulses(32'hA5, 1);
    sb_q.push_back('{name: "ch0_before_reset", check_data: 1'b1, exp: 32'hA5});
    OPB_ABus = BASE + 32'h8;
    OPB_RNW = 1'b1;
    OPB_select = 1'b1;
    @(negedge clk);
    check("ack_before_reset", 32'(Sl_xferAck), 32'd1);
    OPB_select = 1'b0;
    #1 rst_n = 1'b0;
    #1;
    check("reset_async_xferack", 32'(Sl_xferAck), 32'd0);
    check("reset_async_dbus", Sl_DBus, 32'd0);
    check("reset_async_snap_done", 32'(snap_done), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    rd(8'h04, 32'h0, "status_after_async_reset");
    rd(8'h00, 32'h0, "ctrl_after_async_reset");
    rd(8'h08, 32'h0, "ch0_after_async_reset");
    check("scoreboard_drained", 32'(sb_q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
